dma_axi_master: RTL

DMA_AXI_MASTER -- requirements
Module: dma_axi_master

---
 rtl/dma_axi_master.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/dma_axi_master.sv
// DMA AXI master: reads 16-beat bursts from the source address into a 16x32 FIFO, writes them out as a burst to the destination address.
// Latency: a read beat is in the FIFO the cycle after its RVALID/RREADY handshake; the FIFO head drives WDATA as soon as the write engine is in its data phase.
// Backpressure: RREADY drops while the FIFO is full; WVALID drops while the FIFO is empty; a stalled beat is held, never dropped.
// Ports:
//   clk, rstn                         clock, asynchronous active-low reset
//   master_read/master_write          requests from the DMA controller, held until the matching complete flag is seen
//   DMASRC_addr/DMADST_addr           burst byte addresses, forced to word alignment
//   read_ready/write_ready            engine idle indicators (write also needs data in the FIFO)
//   read_complete/write_complete      burst done, held until the request drops
//   fifo_full/fifo_empty              FIFO occupancy flags
//   AR*/R*, AW*/W*/B*                 AXI read and write channels (fixed size, INCR, WSTRB all-ones outside this block)
module dma_axi_master (
  input  logic        clk,
  input  logic        rstn,
  input  logic        master_read,
  input  logic        master_write,
  input  logic [31:0] DMASRC_addr,
  input  logic [31:0] DMADST_addr,
  output logic        read_ready,
  output logic        write_ready,
  output logic        read_complete,
  output logic        write_complete,
  output logic        fifo_full,
  output logic        fifo_empty,
  output logic [31:0] ARADDR,
  output logic [3:0]  ARLEN,
  output logic        ARVALID,
  input  logic        ARREADY,
  input  logic [31:0] RDATA,
  input  logic        RLAST,
  input  logic        RVALID,
  output logic        RREADY,
  output logic [31:0] AWADDR,
  output logic [3:0]  AWLEN,
  output logic        AWVALID,
  input  logic        AWREADY,
  output logic [31:0] WDATA,
  output logic        WLAST,
  output logic        WVALID,
  input  logic        WREADY,
  input  logic        BVALID,
  output logic        BREADY
);

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_ADDR = 2'd1;
  localparam logic [1:0] R_DATA = 2'd2;
  localparam logic [1:0] R_DONE = 2'd3;

  localparam logic [2:0] W_IDLE = 3'd0;
  localparam logic [2:0] W_ADDR = 3'd1;
  localparam logic [2:0] W_DATA = 3'd2;
  localparam logic [2:0] W_RESP = 3'd3;
  localparam logic [2:0] W_DONE = 3'd4;

  logic [1:0]  rstate;
  logic [2:0]  wstate;
  logic [3:0]  rbeat;
  logic [3:0]  wbeat;
  logic [31:0] mem [16];
  logic [3:0]  wr_ptr;
  logic [3:0]  rd_ptr;
  logic [4:0]  count;
  logic        push;
  logic        pop;
  logic [3:0]  awlen_entry;

  // Byte-offset bits are dropped on purpose: bursts are always word aligned.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{DMASRC_addr[1:0], DMADST_addr[1:0]};

  assign fifo_full   = (count == 5'd16);
  assign fifo_empty  = (count == 5'd0);
  assign read_ready  = (rstate == R_IDLE);
  assign write_ready = (wstate == W_IDLE) && !fifo_empty;

  assign ARVALID       = (rstate == R_ADDR);
  assign RREADY        = (rstate == R_DATA) && !fifo_full;
  assign read_complete = (rstate == R_DONE);

  assign AWVALID        = (wstate == W_ADDR);
  assign WVALID         = (wstate == W_DATA) && !fifo_empty;
  // Zero outside the data phase so the bus is quiet in reset and between bursts.
  assign WDATA          = WVALID ? mem[rd_ptr] : 32'd0;
  assign WLAST          = WVALID && (wbeat == AWLEN);
  assign BREADY         = (wstate == W_RESP);
  assign write_complete = (wstate == W_DONE);

  assign push = RVALID && RREADY;
  assign pop  = WVALID && WREADY;

  // Burst length follows what is already buffered; a full FIFO caps at 16 beats.
  assign awlen_entry = count[4] ? 4'd15 : (count[3:0] - 4'd1);

  // Storage carries no reset: count/pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= RDATA;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= 4'd0;
      rd_ptr <= 4'd0;
      count  <= 5'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 4'd1;
      if (pop)  rd_ptr <= rd_ptr + 4'd1;
      if (push && !pop)      count <= count + 5'd1;
      else if (pop && !push) count <= count - 5'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rstate <= R_IDLE;
      rbeat  <= 4'd0;
      ARADDR <= 32'd0;
      ARLEN  <= 4'd0;
    end else begin
      case (rstate)
        R_IDLE: if (master_read) begin
          ARADDR <= {DMASRC_addr[31:2], 2'b00};
          ARLEN  <= 4'd15;
          rstate <= R_ADDR;
        end
        R_ADDR: if (ARREADY) begin
          rbeat  <= 4'd0;
          rstate <= R_DATA;
        end
        R_DATA: if (push) begin
          rbeat <= rbeat + 4'd1;
          // An early RLAST ends the burst short; otherwise stop after 16 beats.
          if (RLAST || rbeat == 4'd15) rstate <= R_DONE;
        end
        default: if (!master_read) rstate <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wstate <= W_IDLE;
      wbeat  <= 4'd0;
      AWADDR <= 32'd0;
      AWLEN  <= 4'd0;
    end else begin
      case (wstate)
        W_IDLE: if (master_write && !fifo_empty) begin
          AWADDR <= {DMADST_addr[31:2], 2'b00};
          AWLEN  <= awlen_entry;
          wstate <= W_ADDR;
        end
        W_ADDR: if (AWREADY) begin
          wbeat  <= 4'd0;
          wstate <= W_DATA;
        end
        W_DATA: if (pop) begin
          wbeat <= wbeat + 4'd1;
          if (wbeat == AWLEN) wstate <= W_RESP;
        end
        W_RESP: if (BVALID) wstate <= W_DONE;
        W_DONE: if (!master_write) wstate <= W_IDLE;
        default: wstate <= W_IDLE;
      endcase
    end
  end

endmodule
